// File: rtl/radix4div_pkg.sv
// radix4div_pkg: shared widths, iteration count and FSM encoding for the
// radix-4 restoring divider (16-bit dividend / 8-bit divisor).
package radix4div_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int REM_W      = 10;   // partial remainder, wide enough for 3D
    localparam int ITERATIONS = 8;    // DIVIDEND_W / 2 digits
    localparam int CNT_W      = $clog2(ITERATIONS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/radix4div_digit.sv
// radix4div_digit: one radix-4 quotient digit selection step.
// Picks the largest k in {0,1,2,3} with k*D <= R' and returns R' - k*D.
// Ports:
//   r_sh  in  10  shifted partial remainder R'
//   d     in   8  divisor D
//   d2    in   9  2D
//   d3    in  10  3D
//   k     out  2  quotient digit
//   r_out out 10  R' - k*D
module radix4div_digit
    import radix4div_pkg::*;
(
    input  logic [REM_W-1:0]     r_sh,
    input  logic [DIVISOR_W-1:0] d,
    input  logic [DIVISOR_W:0]   d2,
    input  logic [REM_W-1:0]     d3,
    output logic [1:0]           k,
    output logic [REM_W-1:0]     r_out
);

    logic [REM_W-1:0] d1_ext;
    logic [REM_W-1:0] d2_ext;

    assign d1_ext = {2'b00, d};
    assign d2_ext = {1'b0, d2};

    // Full-width compares: no multiple is truncated before comparison.
    always_comb begin
        k     = 2'd0;
        r_out = r_sh;
        if (r_sh >= d3) begin
            k     = 2'd3;
            r_out = r_sh - d3;
        end else if (r_sh >= d2_ext) begin
            k     = 2'd2;
            r_out = r_sh - d2_ext;
        end else if (r_sh >= d1_ext) begin
            k     = 2'd1;
            r_out = r_sh - d1_ext;
        end
    end

endmodule

// File: rtl/radix4div.sv
// radix4div: sequential unsigned radix-4 divider, 16-bit / 8-bit,
// two quotient bits per clock, 8 iterations, done 9 cycles after start.
// Ports:
//   clk       in   1  rising-edge clock
//   rst_n     in   1  synchronous active-low reset
//   start     in   1  request, accepted in IDLE or DONE
//   dividend  in  16  numerator, captured on accept
//   divisor   in   8  denominator, captured on accept
//   busy      out  1  high while iterating
//   done      out  1  one-cycle result-valid pulse
//   quotient  out 16  held until the next done
//   remainder out  8  held until the next done
//   dbz       out  1  divide-by-zero flag, valid with done
// Optional feature: define RADIX4DIV_DBZ_EN to short-circuit zero divisors
// straight to DONE with dbz=1, quotient=16'hFFFF, remainder=dividend[7:0].
// Without it dbz is tied low and zero divisors iterate normally.
module radix4div
    import radix4div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  dbz
);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] sr_q, sr_d;
    logic [DIVIDEND_W-1:0] quo_sr_q, quo_sr_d;
    logic [DIVISOR_W-1:0]  d_q, d_d;
    logic [REM_W-1:0]      d3_q, d3_d;
    logic [REM_W-1:0]      r_q, r_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
`ifdef RADIX4DIV_DBZ_EN
    logic                  dbz_q, dbz_d;
`endif

    logic [REM_W-1:0]      r_sh;
    logic [REM_W-1:0]      r_nxt;
    logic [1:0]            k;
    logic [DIVISOR_W:0]    d2;
    logic [DIVIDEND_W-1:0] quo_nxt;
    logic                  accept;

    // R < D <= 255 after every step, so only R[7:0] carries into R'.
    assign r_sh    = REM_W'({r_q, sr_q[DIVIDEND_W-1 -: 2]});
    assign d2      = {d_q, 1'b0};
    assign quo_nxt = (quo_sr_q << 2) | DIVIDEND_W'(k);
    assign accept  = start && (state_q == S_IDLE || state_q == S_DONE);

    radix4div_digit u_digit (
        .r_sh  (r_sh),
        .d     (d_q),
        .d2    (d2),
        .d3    (d3_q),
        .k     (k),
        .r_out (r_nxt)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        quo_sr_d    = quo_sr_q;
        d_d         = d_q;
        d3_d        = d3_q;
        r_d         = r_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
`ifdef RADIX4DIV_DBZ_EN
        dbz_d       = dbz_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    sr_d     = dividend;
                    d_d      = divisor;
                    d3_d     = {2'b00, divisor} + {1'b0, divisor, 1'b0};
                    r_d      = '0;
                    quo_sr_d = '0;
                    cnt_d    = CNT_W'(ITERATIONS - 1);
                    state_d  = S_CALC;
`ifdef RADIX4DIV_DBZ_EN
                    if (divisor == '0) begin
                        state_d     = S_DONE;
                        quotient_d  = '1;
                        remainder_d = dividend[DIVISOR_W-1:0];
                        dbz_d       = 1'b1;
                    end
`endif
                end
            end
            S_CALC: begin
                r_d      = r_nxt;
                quo_sr_d = quo_nxt;
                sr_d     = sr_q << 2;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d     = S_DONE;
                    quotient_d  = quo_nxt;
                    remainder_d = r_nxt[DIVISOR_W-1:0];
`ifdef RADIX4DIV_DBZ_EN
                    dbz_d       = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Status outputs are registered copies of the next state.
        busy_d = (state_d == S_CALC);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            quo_sr_q    <= '0;
            d_q         <= '0;
            d3_q        <= '0;
            r_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef RADIX4DIV_DBZ_EN
            dbz_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            quo_sr_q    <= quo_sr_d;
            d_q         <= d_d;
            d3_q        <= d3_d;
            r_q         <= r_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef RADIX4DIV_DBZ_EN
            dbz_q       <= dbz_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
`ifdef RADIX4DIV_DBZ_EN
    assign dbz       = dbz_q;
`else
    assign dbz       = 1'b0;
`endif

endmodule

// File: tb/tb_radix4div.sv
// tb_radix4div: self-checking bench for radix4div. Expected results come
// from plain integer division; directed cases plus 50 random x*y / y pairs.
module tb_radix4div;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        dbz;

    int          n_chk;
    int          n_err;
    logic [15:0] last_q;

    radix4div dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request from the current cycle (#1 after an edge) and return
    // in the done cycle. inj>0 drives a spurious start on that busy cycle.
    task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs, input int inj);
        int          cyc;
        int          elat;
        logic [15:0] eq;
        logic [7:0]  er;
        logic        edbz;
        bit          chk_r;
        elat  = 9;
        edbz  = 1'b0;
        chk_r = 1'b1;
        if (dvs != 0) begin
            eq = dvd / dvs;
            er = 8'(dvd % dvs);
        end else begin
            eq = 16'hFFFF;
            er = dvd[7:0];
`ifdef RADIX4DIV_DBZ_EN
            elat = 1;
            edbz = 1'b1;
`else
            chk_r = 1'b0;
`endif
        end
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        if (elat > 1) chk("hold_q", quotient, last_q);
        while (!done && cyc < 40) begin
            chk("busy", busy, 1);
            if (cyc == inj) begin
                start    = 1'b1;
                dividend = 16'($urandom);
                divisor  = 8'($urandom_range(1, 255));
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            chk("excl", busy & done, 0);
        end
        chk("latency", cyc, elat);
        chk("quotient", quotient, eq);
        if (chk_r) chk("remainder", remainder, er);
        chk("dbz", dbz, edbz);
        last_q = eq;
    endtask

    initial begin
        logic [7:0] x;
        logic [7:0] y;
        n_chk    = 0;
        n_err    = 0;
        last_q   = 16'h0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 16'h0;
        divisor  = 8'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", dbz, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);

        // Directed cases, issued back-to-back from each done cycle.
        run_op(16'h7530, 8'd150, 0);
        run_op(16'hFFFF, 8'hFF, 0);
        run_op(16'hFFFF, 8'h01, 0);
        run_op(16'd1000, 8'd7, 0);
        run_op(16'd5, 8'd9, 0);

        // Spurious start mid-operation must be ignored.
        @(posedge clk); #1;
        run_op(16'd40000, 8'd200, 3);
        run_op(16'd12345, 8'd99, 8);

        // Reset during cycle 4 of an operation.
        @(posedge clk); #1;
        dividend = 16'hBEEF;
        divisor  = 8'd13;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_q", quotient, 0);
        chk("mid_rst_r", remainder, 0);
        rst_n  = 1'b1;
        last_q = 16'h0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("no_done", done, 0);
        end

        // Zero divisor: short-circuit with the feature, natural FFFF without.
        run_op(16'h1234, 8'h00, 0);
        run_op(16'd1000, 8'd7, 0);

        // Random products must divide exactly back to the other factor.
        for (int i = 0; i < 50; i++) begin
            x = 8'($urandom_range(1, 254));
            y = 8'($urandom_range(1, 254));
            run_op(16'(x) * 16'(y), y, 0);
            chk("rand_x", quotient, {8'h0, x});
            chk("rand_r0", remainder, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/radix4div.md
# radix4div

Sequential unsigned radix-4 divider, 16-bit dividend by 8-bit divisor, producing 2 quotient bits per clock. It inverts the radix-4 8x8 accurate multiplier. Feeding its 16-bit product back with either operand as divisor must reproduce the other operand with zero remainder. It serves as the self-check engine in the approximate/accurate multiplier evaluation flow.

## Interface
- Parameters: none; widths are fixed by the shared package.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous and active-low, sampled on the rising edge of clk
- start  in  1  request; sampled only in IDLE or DONE
- dividend  in  16  unsigned numerator; captured on accepted start
- divisor  in  8  unsigned denominator; captured on accepted start
- busy  out  1  high while iterating (CALC)
- done  out  1  one-cycle pulse; quotient/remainder valid
- quotient  out  16  unsigned quotient; held until next done
- remainder  out  8  unsigned remainder, always < divisor for divisor ≠ 0
- dbz  out  1  divide-by-zero flag; valid with done

## Operation
- States:
  - IDLE: waits for start.
  - CALC: iterates.
  - DONE: pulses done for one cycle.
- Transitions:
  - IDLE --start--> CALC.
  - CALC --iteration count reaches 0--> DONE.
  - DONE --start--> CALC (back-to-back), else IDLE.
- On accept:
  - Latch dividend into a shift register and divisor into D.
  - Precompute 3D (10 bits).
  - Clear the partial remainder (10 bits) and set the iteration counter to 7.
- Each CALC cycle:
  - R' = {R[7:0], dividend_sr[15:14]}.
  - Select the largest digit k in {0,1,2,3} with k·D ≤ R'.
  - R = R' − k·D.
  - Shift the quotient left by 2 and insert k.
  - Shift dividend_sr left by 2.
  - Decrement the counter.
- Exactly 8 CALC cycles are performed. The final remainder is R[7:0].
- Quotient and remainder update only on entry to DONE and hold until the next DONE.
- start while busy is ignored, with no effect on the in-flight operation.
- All arithmetic is unsigned. 3D uses 10 bits and 2D uses 9 bits. No truncation before comparison.

## Timing
- Reset values: busy=0, done=0, dbz=0, quotient=16'h0000, remainder=8'h00, state=IDLE.
- Sequence:
  - start sampled high in cycle 0 → busy=1 in cycles 1–8.
  - done=1 in cycle 9 only, with results valid in the same cycle.
  - Latency is 9 cycles.
- Back-to-back: start high during the done cycle → busy=1 the next cycle. Throughput is one result per 9 cycles.
- Reset mid-operation: on the next edge, return to IDLE with reset output values. No done is produced for the aborted request.
- done and busy are never high simultaneously.

## Configuration
- RADIX4DIV_DBZ_EN defined:
  - divisor==0 on accept goes IDLE→DONE directly, skipping CALC.
  - done is asserted the cycle after accept, with dbz=1, quotient=16'hFFFF, remainder=dividend[7:0].
  - dbz=0 for all nonzero divisors.
- Not defined:
  - dbz is tied 0 and zero divisors run the normal 8-cycle iteration.
  - quotient=16'hFFFF is produced naturally; remainder is unspecified and must not be checked.

## Structure
- Package radix4div_pkg holds:
  - Widths: DIVIDEND_W=16, DIVISOR_W=8, REM_W=10.
  - ITERATIONS=8.
  - State encoding for IDLE, CALC, DONE.
- One combinational sub-module, radix4div_digit:
  - Inputs: R', D, 2D, 3D.
  - Outputs: digit k (2 bits) and R'−k·D.
- FSM, counter and registers live in radix4div.

## Test plan
- 16'h7530 / 8'd150 (product of 200×150) → done at cycle 9, quotient=16'h00C8, remainder=0, dbz=0.
- 16'hFFFF / 8'hFF → quotient=16'h0101, remainder=0. 16'hFFFF / 8'h01 → quotient=16'hFFFF, remainder=0.
- 16'd1000 / 8'd7 → quotient=142, remainder=6. 16'd5 / 8'd9 → quotient=0, remainder=5.
- Second start with different operands during cycles 1–8 → ignored; first result delivered unchanged. Start during done cycle → second result exactly 9 cycles later.
- rst_n low in cycle 4 of an operation → next cycle busy=0, outputs zero; no done follows until a new start.
- With RADIX4DIV_DBZ_EN: 16'h1234 / 0 → done at cycle 1, dbz=1, quotient=16'hFFFF, remainder=8'h34.
- Randomised: 50 pairs of x,y in 1..254, dividend=x·y, divisor=y → quotient==x and remainder==0 for every pair.
